// File: rtl/ct_pkg.sv
// Shared constants and elaboration helpers for the ct_mux_pipe block.
package ct_pkg;

    localparam int CT_SEL_BINARY = 0;
    localparam int CT_SEL_ONEHOT = 1;

    localparam int CT_MIN_SIZE   = 2;
    localparam int CT_MAX_SIZE   = 64;
    localparam int CT_MAX_STAGES = 8;

    // Number of bits needed to encode 'value' distinct codes (clog2(1) == 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ct_mux_pipe_if.sv
// Valid/ready stream link between pipeline stages; master drives payload, slave drives ready.
interface ct_mux_pipe_if #(
    parameter int WIDTH = 8
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/ct_pipe_stage.sv
// One elastic register stage: a valid flag plus WIDTH-bit payload with pass-through ready.
module ct_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    ct_mux_pipe_if.slave  up,
    ct_mux_pipe_if.master dn
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             advance;

    // Taking a new item is safe when empty or when our own item leaves this cycle.
    assign advance = !valid_q || dn.ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = up.valid;
            if (up.valid) begin
                data_d = up.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign up.ready = advance;
    assign dn.valid = valid_q;
    assign dn.data  = data_q;

endmodule

// File: rtl/ct_mux_pipe.sv
// Channel multiplexer (binary or one-hot select) followed by a PIPELINE-deep elastic pipeline.
module ct_mux_pipe
    import ct_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SIZE     = 4,
    parameter int SELW     = 2,
    parameter int PIPELINE = 2,
    parameter int ONEHOT   = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WIDTH*SIZE-1:0]   i_data,
    input  logic [SELW-1:0]         i_sel,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_busy
);

    generate
        if (SIZE < CT_MIN_SIZE || SIZE > CT_MAX_SIZE) begin : g_bad_size
            $fatal(1, "ct_mux_pipe: SIZE must be within 2..64");
        end
        if (PIPELINE < 0 || PIPELINE > CT_MAX_STAGES) begin : g_bad_pipe
            $fatal(1, "ct_mux_pipe: PIPELINE must be within 0..8");
        end
        if (ONEHOT != CT_SEL_BINARY && ONEHOT != CT_SEL_ONEHOT) begin : g_bad_mode
            $fatal(1, "ct_mux_pipe: ONEHOT must be 0 or 1");
        end
        if (ONEHOT == CT_SEL_BINARY && SELW < clog2(SIZE)) begin : g_bad_selw_bin
            $fatal(1, "ct_mux_pipe: SELW too narrow for binary select");
        end
        if (ONEHOT == CT_SEL_ONEHOT && SELW != SIZE) begin : g_bad_selw_oh
            $fatal(1, "ct_mux_pipe: one-hot select needs SELW == SIZE");
        end
    endgenerate

    // AND stage: each channel is gated by its own select decode.
    logic [WIDTH-1:0] chan_masked [SIZE];

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_chan
        logic hit;
        if (ONEHOT == CT_SEL_ONEHOT) begin : g_oh
            assign hit = i_sel[gi];
        end else begin : g_bin
            // Out-of-range codes match no channel, so the OR below yields zero.
            assign hit = (i_sel == SELW'(gi));
        end
        assign chan_masked[gi] = hit ? i_data[gi*WIDTH +: WIDTH] : '0;
    end

    // OR stage: binary mode has at most one live term, one-hot mode merges all selected.
    logic [WIDTH-1:0] mux_result;

    always_comb begin
        mux_result = '0;
        for (int k = 0; k < SIZE; k++) begin
            mux_result = mux_result | chan_masked[k];
        end
    end

    generate
        if (PIPELINE == 0) begin : g_comb
            assign o_data  = mux_result;
            assign o_valid = i_valid;
            assign o_ready = i_ready;
            assign o_busy  = 1'b0;
        end else begin : g_pipe
            ct_mux_pipe_if #(.WIDTH(WIDTH)) link [PIPELINE+1] ();
            logic [PIPELINE-1:0] stage_valid;

            assign link[0].valid = i_valid;
            assign link[0].data  = mux_result;
            assign o_ready       = link[0].ready;

            for (genvar gi = 0; gi < PIPELINE; gi++) begin : g_stage
                ct_pipe_stage #(
                    .WIDTH (WIDTH)
                ) u_stage (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .up      (link[gi]),
                    .dn      (link[gi+1])
                );
                assign stage_valid[gi] = link[gi+1].valid;
            end

            assign link[PIPELINE].ready = i_ready;
            assign o_valid              = link[PIPELINE].valid;
            assign o_data               = link[PIPELINE].data;
            assign o_busy               = |stage_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ct_mux_pipe.sv
// Bench for ct_mux_pipe: three configurations checked every cycle against a queue-based model.
module tb_ct_mux_pipe;

    localparam int ND = 3;

    // dut 0: binary SIZE=4 P=2; dut 1: binary SIZE=3 SELW=2 P=3; dut 2: one-hot SIZE=4 P=1
    function automatic int p_of(input int d);
        case (d)
            0: return 2;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int size_of(input int d);
        return (d == 1) ? 3 : 4;
    endfunction

    function automatic int selw_of(input int d);
        return (d == 2) ? 4 : 2;
    endfunction

    function automatic bit oh_of(input int d);
        return d == 2;
    endfunction

    // Selection rules written straight from the channel/select definitions.
    function automatic logic [7:0] mux_ref(input int d, input logic [31:0] data, input logic [3:0] s);
        logic [7:0] r;
        r = 8'h00;
        if (oh_of(d)) begin
            for (int k = 0; k < size_of(d); k++) begin
                if (s[k]) r = r | data[k*8 +: 8];
            end
        end else if (int'(s) < size_of(d)) begin
            r = data[int'(s)*8 +: 8];
        end
        return r;
    endfunction

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   din [ND];
    logic [3:0]    sel [ND];
    logic [ND-1:0] vld;
    logic [ND-1:0] rdy;
    logic [ND-1:0] ordy;
    logic [ND-1:0] ov;
    logic [ND-1:0] busy;
    logic [7:0]    dout [ND];

    ct_mux_pipe_if #(.WIDTH(8)) if_a ();
    ct_mux_pipe_if #(.WIDTH(8)) if_b ();
    ct_mux_pipe_if #(.WIDTH(8)) if_c ();

    assign if_a.ready = rdy[0];
    assign if_b.ready = rdy[1];
    assign if_c.ready = rdy[2];
    assign dout[0] = if_a.data;
    assign dout[1] = if_b.data;
    assign dout[2] = if_c.data;
    assign ov = {if_c.valid, if_b.valid, if_a.valid};

    ct_mux_pipe #(.WIDTH(8), .SIZE(4), .SELW(2), .PIPELINE(2), .ONEHOT(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_data(din[0]), .i_sel(sel[0][1:0]),
        .i_valid(vld[0]), .o_ready(ordy[0]), .o_data(if_a.data), .o_valid(if_a.valid),
        .i_ready(if_a.ready), .o_busy(busy[0]));

    ct_mux_pipe #(.WIDTH(8), .SIZE(3), .SELW(2), .PIPELINE(3), .ONEHOT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_data(din[1][23:0]), .i_sel(sel[1][1:0]),
        .i_valid(vld[1]), .o_ready(ordy[1]), .o_data(if_b.data), .o_valid(if_b.valid),
        .i_ready(if_b.ready), .o_busy(busy[1]));

    ct_mux_pipe #(.WIDTH(8), .SIZE(4), .SELW(4), .PIPELINE(1), .ONEHOT(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .i_data(din[2]), .i_sel(sel[2]),
        .i_valid(vld[2]), .o_ready(ordy[2]), .o_data(if_c.data), .o_valid(if_c.valid),
        .i_ready(if_c.ready), .o_busy(busy[2]));

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Model: a FIFO of accepted results tagged with the negedge index of acceptance.
    logic [7:0] m_data [ND][8];
    int         m_acc  [ND][8];
    int         m_cnt  [ND];
    int         n_acc  [ND];
    int         n_cons [ND];
    int         k_now = 0;

    initial begin
        for (int d = 0; d < ND; d++) begin
            m_cnt[d] = 0; n_acc[d] = 0; n_cons[d] = 0;
        end
        forever begin
            @(negedge clk);
            k_now++;
            for (int d = 0; d < ND; d++) begin
                if (!reset_n) begin
                    check("rst_valid", d, 32'(ov[d]), 32'd0);
                    check("rst_busy", d, 32'(busy[d]), 32'd0);
                    check("rst_ready", d, 32'(ordy[d]), 32'd1);
                    m_cnt[d] = 0;
                end else begin
                    bit exp_ready, exp_valid;
                    exp_ready = (m_cnt[d] < p_of(d)) || rdy[d];
                    exp_valid = (m_cnt[d] > 0) && (k_now - m_acc[d][0] >= p_of(d));
                    check("o_ready", d, 32'(ordy[d]), 32'(exp_ready));
                    check("o_valid", d, 32'(ov[d]), 32'(exp_valid));
                    check("o_busy", d, 32'(busy[d]), 32'(m_cnt[d] > 0));
                    if (exp_valid) check("o_data", d, 32'(dout[d]), 32'(m_data[d][0]));
                    if (exp_valid && rdy[d]) begin
                        $display("dut%0d out #%0d data=%02h", d, n_cons[d], m_data[d][0]);
                        for (int i = 0; i < 7; i++) begin
                            m_data[d][i] = m_data[d][i+1];
                            m_acc[d][i]  = m_acc[d][i+1];
                        end
                        m_cnt[d]--;
                        n_cons[d]++;
                    end
                    if (vld[d] && exp_ready) begin
                        m_data[d][m_cnt[d]] = mux_ref(d, din[d], sel[d]);
                        m_acc[d][m_cnt[d]]  = k_now;
                        m_cnt[d]++;
                        n_acc[d]++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc [ND];
        int base_cons [ND];
        int cyc;
        bool_loop: begin end
        for (int d = 0; d < ND; d++) begin
            din[d] = '0; sel[d] = '0;
        end
        vld = '0;
        rdy = '1;

        // Model pins: literal results for the reference selection rules.
        check("ref_bin", 0, 32'(mux_ref(0, 32'h44332211, 4'd2)), 32'h33);
        check("ref_oor", 1, 32'(mux_ref(1, 32'h00CCBBAA, 4'd3)), 32'h00);
        check("ref_oh", 2, 32'(mux_ref(2, 32'h00F0000F, 4'b0101)), 32'hFF);
        check("ref_oh0", 2, 32'(mux_ref(2, 32'h00F0000F, 4'b0000)), 32'h00);

        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // Directed: binary, out-of-range and one-hot items with exact latency.
        @(posedge clk); #1;
        din[0] = 32'h44332211; sel[0] = 4'd2;
        din[1] = 32'h00CCBBAA; sel[1] = 4'd3;
        din[2] = 32'h00F0000F; sel[2] = 4'b0101;
        vld = 3'b111;
        @(posedge clk); #1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        sel[2] = 4'b0000;
        @(negedge clk);
        check("dir_oh_valid", 2, 32'(ov[2]), 32'd1);
        check("dir_oh_data", 2, 32'(dout[2]), 32'hFF);
        check("dir_bin_early", 0, 32'(ov[0]), 32'd0);
        @(posedge clk); #1;
        vld[2] = 1'b0;
        @(negedge clk);
        check("dir_bin_valid", 0, 32'(ov[0]), 32'd1);
        check("dir_bin_data", 0, 32'(dout[0]), 32'h33);
        check("dir_oor_early", 1, 32'(ov[1]), 32'd0);
        check("dir_oh0_data", 2, 32'(dout[2]), 32'h00);
        @(negedge clk);
        check("dir_oor_valid", 1, 32'(ov[1]), 32'd1);
        check("dir_oor_data", 1, 32'(dout[1]), 32'h00);
        repeat (3) @(posedge clk);

        // Backpressure on the P=3 instance: 10 items, downstream stalled for cycles 4..9.
        base_acc[1] = n_acc[1]; base_cons[1] = n_cons[1];
        cyc = 0;
        while ((n_cons[1] - base_cons[1] < 10) && cyc < 200) begin
            @(posedge clk); #1;
            rdy[1] = !(cyc >= 4 && cyc <= 9);
            vld[1] = (n_acc[1] - base_acc[1]) < 10;
            din[1] = $urandom;
            sel[1] = 4'($urandom_range(0, 3));
            @(negedge clk);
            if (cyc == 9) begin
                check("bp_ready_low", 1, 32'(ordy[1]), 32'd0);
                check("bp_busy", 1, 32'(busy[1]), 32'd1);
            end
            cyc++;
        end
        vld[1] = 1'b0; rdy[1] = 1'b1;
        check("bp_count", 1, 32'(n_cons[1] - base_cons[1]), 32'd10);

        // Random traffic: 1000 items into every instance.
        for (int d = 0; d < ND; d++) begin
            base_acc[d] = n_acc[d]; base_cons[d] = n_cons[d];
        end
        cyc = 0;
        while (cyc < 20000) begin
            bit done;
            @(posedge clk); #1;
            done = 1'b1;
            for (int d = 0; d < ND; d++) begin
                vld[d] = ((n_acc[d] - base_acc[d]) < 1000) && ($urandom_range(0, 3) != 0);
                rdy[d] = $urandom_range(0, 3) != 0;
                din[d] = $urandom;
                sel[d] = 4'($urandom_range(0, (1 << selw_of(d)) - 1));
                if ((n_acc[d] - base_acc[d]) < 1000 || m_cnt[d] != 0) done = 1'b0;
            end
            if (done) break;
            cyc++;
        end
        vld = '0; rdy = '1;
        for (int d = 0; d < ND; d++) begin
            check("rand_count", d, 32'(n_cons[d] - base_cons[d]), 32'd1000);
        end

        // Reset with two items in flight on dut 0, then accept on the first edge after release.
        @(posedge clk); #1;
        rdy[0] = 1'b0; vld[0] = 1'b1; din[0] = 32'hA1B2C3D4; sel[0] = 4'd1;
        @(posedge clk); #1;
        sel[0] = 4'd3;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(negedge clk);
        check("inflight_busy", 0, 32'(busy[0]), 32'd1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_valid", 0, 32'(ov[0]), 32'd0);
        check("async_busy", 0, 32'(busy[0]), 32'd0);
        check("async_ready", 0, 32'(ordy[0]), 32'd1);
        base_cons[0] = n_cons[0];
        @(posedge clk); #3;
        reset_n = 1'b1;
        rdy[0] = 1'b1; vld[0] = 1'b1; din[0] = 32'h5566AA77; sel[0] = 4'd0;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_count", 0, 32'(n_cons[0] - base_cons[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
